vga_frame_monitor: RTL

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_monitor.sv
// VGA frame monitor: checks sync timing of an incoming raster, locks onto a
// compliant stream, captures active pixels and keeps a per-frame checksum.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_b,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        clr_err,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [23:0] pixel_rgb,
  output logic        frame_done,
  output logic [31:0] frame_checksum,
  output logic [15:0] frame_count,
  output logic        locked,
  output logic [3:0]  err
);

  localparam logic [10:0] HTOT = 11'(H_TOTAL);
  localparam logic [9:0]  HSYN = 10'(H_SYNC);
  localparam logic [9:0]  HACT = 10'(H_ACTIVE);
  localparam logic [9:0]  VACT = 10'(V_ACTIVE);
  localparam logic [9:0]  VTOT = 10'(V_TOTAL);
  localparam logic [9:0]  CMAX = '1;

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;
  state_t state, state_nxt;

  logic        hs_q, hs_p, vs_q, vs_p, bl_q, clr_q;
  logic [23:0] rgb_q;
  logic [9:0]  hcnt, hlow, vcnt, acnt, arow;
  logic        hseen;
  logic [31:0] sum;
  logic        hfall, hrise, vfall, run, capture, frame_end;
  logic [3:0]  err_new;

  assign hfall     = hs_p & ~hs_q;
  assign hrise     = ~hs_p & hs_q;
  assign vfall     = vs_p & ~vs_q;
  assign run       = (state != SEARCH) | vfall;
  assign capture   = (state == LOCKED) & bl_q;
  assign frame_end = (state == LOCKED) & vfall & ~(|err_new);
  assign locked    = (state == LOCKED);

  // Every pin is registered once; the previous sync samples expose edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q  <= 1'b0;
      hs_p  <= 1'b0;
      vs_q  <= 1'b0;
      vs_p  <= 1'b0;
      bl_q  <= 1'b0;
      clr_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hsync;
      hs_p  <= hs_q;
      vs_q  <= vsync;
      vs_p  <= vs_q;
      bl_q  <= blank_b;
      clr_q <= clr_err;
      rgb_q <= {r, g, b};
    end
  end

  // Timing counters idle at zero in SEARCH but start on the vsync edge that leaves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt  <= '0;
      hlow  <= '0;
      vcnt  <= '0;
      acnt  <= '0;
      arow  <= '0;
      hseen <= 1'b0;
    end else if (!run) begin
      hcnt  <= '0;
      hlow  <= '0;
      vcnt  <= '0;
      acnt  <= '0;
      arow  <= '0;
      hseen <= 1'b0;
    end else begin
      if (hfall) hcnt <= '0;
      else if (hcnt != CMAX) hcnt <= hcnt + 10'd1;
      if (hfall) hlow <= 10'd1;
      else if (!hs_q && hlow != CMAX) hlow <= hlow + 10'd1;
      if (vfall) vcnt <= '0;
      else if (hfall && vcnt != CMAX) vcnt <= vcnt + 10'd1;
      if (hfall) acnt <= {9'd0, bl_q};
      else if (bl_q && acnt != CMAX) acnt <= acnt + 10'd1;
      if (vfall) arow <= '0;
      else if (hfall && acnt != '0 && arow != CMAX) arow <= arow + 10'd1;
      hseen <= (state != SEARCH) & (hseen | hfall);
    end
  end

  // hcnt and hlow only mean something once a falling edge has been seen in SYNC/LOCKED.
  always_comb begin
    err_new = '0;
    if (state != SEARCH) begin
      err_new[0] = hfall & hseen & (({1'b0, hcnt} + 11'd1) != HTOT);
      err_new[1] = hrise & hseen & (hlow != HSYN);
      err_new[2] = hfall & (((acnt != '0) & (acnt != HACT)) |
                            ((acnt == HACT) & (arow >= VACT)));
      err_new[3] = vfall & (vcnt != VTOT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vfall) state_nxt = SYNC;
      SYNC: begin
        if (|err_new) state_nxt = SEARCH;
        else if (vfall) state_nxt = LOCKED;
      end
      LOCKED:  if (|err_new) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nxt;
  end

  // A vsync edge always restarts the running sum; it is published only for a clean frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err            <= '0;
      pixel_valid    <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      pixel_rgb      <= '0;
      frame_done     <= 1'b0;
      frame_checksum <= '0;
      frame_count    <= '0;
      sum            <= '0;
    end else begin
      err         <= (clr_q ? 4'd0 : err) | err_new;
      pixel_valid <= capture;
      if (capture) begin
        pixel_x   <= acnt;
        pixel_y   <= arow[8:0];
        pixel_rgb <= rgb_q;
      end
      frame_done <= frame_end;
      if (frame_end) begin
        frame_checksum <= sum;
        frame_count    <= frame_count + 16'd1;
      end
      if (vfall) sum <= '0;
      else if (capture)
        sum <= sum + 32'(rgb_q[23:16]) + 32'(rgb_q[15:8]) + 32'(rgb_q[7:0]);
    end
  end

endmodule
